alu_req_driver: RTL and testbench

Initiator-side front end for the 64-bit ALU: accepts operation requests over a valid/ready handshake, drives the ALU operand/opcode ports from registers, captures the combinational result and zero flag, and returns tagged responses through a small response FIFO with backpressure. It sits between an issue stage, or a hardware self-test sequencer, and the ALU's input/output ports, i.e. it plays the role the testbench side of the ALU interface plays in simulation.

---
 rtl/alu_req_driver_pkg.sv | 17 +
 rtl/alu_req_driver_if.sv | 16 +
 rtl/alu_req_driver_rsp_fifo.sv | 51 +++++
 rtl/alu_req_driver.sv | 107 ++++++++++
 tb/tb_alu_req_driver.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_driver_pkg.sv
// Shared ALU types: 64-bit data word and the ALU operation encoding.
package alu_req_driver_pkg;

  typedef logic [63:0] dword_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluop_t;

endpackage

// File: rtl/alu_req_driver_if.sv
// ALU port bundle. The initiator drives operands/opcode and observes the
// combinational result; the alu side is the reverse view.
interface alu_req_driver_if;
  import alu_req_driver_pkg::*;

  dword_t porta;
  dword_t portb;
  aluop_t ALUOp;
  dword_t aluout;
  logic   zero;

  modport initiator (output porta, output portb, output ALUOp,
                     input  aluout, input  zero);
  modport alu       (input  porta, input  portb, input  ALUOp,
                     output aluout, output zero);
endinterface

// File: rtl/alu_req_driver_rsp_fifo.sv
// Small synchronous FIFO with occupancy count, async reset and sync flush.
module alu_req_driver_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_rd, do_wr;

  // Reads only from a non-empty FIFO; a write into a full FIFO is only
  // accepted when the head leaves on the same edge.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && ((count != CW'(DEPTH)) || do_rd);

  assign rd_data = mem[rp];

  // Pointer and occupancy update; flush empties regardless of traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/alu_req_driver.sv
// Initiator front end for the 64-bit ALU: registers a request onto the ALU
// ports, captures the settled result one cycle later into a response FIFO,
// and returns tagged responses in acceptance order with backpressure.
module alu_req_driver
  import alu_req_driver_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  dword_t               req_a,
  input  dword_t               req_b,
  input  aluop_t               req_op,
  input  logic [TAG_W-1:0]     req_tag,
  alu_req_driver_if.initiator  alu,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output dword_t               rsp_result,
  output logic                 rsp_zero,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          op_count
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    dword_t           result;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  dword_t           porta_q, portb_q;
  aluop_t           op_q;
  logic [TAG_W-1:0] tag_q;
  logic             inflight;
  logic             accept, pop, fifo_wr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW:0]      occ_n;
  logic [RSP_W-1:0] fifo_rd;
  rsp_t             wr_rsp, head;

  assign accept  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;
  assign fifo_wr = inflight && !flush;

  // Slots that stay committed after this edge: queued + in-flight - leaving.
  // pop implies a non-empty FIFO, so this never underflows.
  assign occ_n     = (CW+1)'(fifo_cnt) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req_ready = !RST && !flush && (occ_n < (CW+1)'(RSP_DEPTH));

  assign alu.porta = porta_q;
  assign alu.portb = portb_q;
  assign alu.ALUOp = op_q;

  // Operand/opcode/tag registers load on accept and hold while idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      porta_q <= '0;
      portb_q <= '0;
      op_q    <= aluop_t'(0);
      tag_q   <= '0;
    end else if (accept) begin
      porta_q <= req_a;
      portb_q <= req_b;
      op_q    <= req_op;
      tag_q   <= req_tag;
    end
  end

  // One op is in flight for the cycle after its accept; flush drops it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        inflight <= 1'b0;
    else if (flush) inflight <= 1'b0;
    else            inflight <= accept;
  end

  // Completed-op counter, stepped whenever a result lands in the FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          op_count <= '0;
    else if (fifo_wr) op_count <= op_count + 32'd1;
  end

  assign wr_rsp = '{result: alu.aluout, zero: alu.zero, tag: tag_q};

  alu_req_driver_rsp_fifo #(.W(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (CLK),
    .rst     (RST),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_data (wr_rsp),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_cnt)
  );

  assign head       = rsp_t'(fifo_rd);
  assign rsp_valid  = (fifo_cnt != '0);
  assign rsp_result = head.result;
  assign rsp_zero   = head.zero;
  assign rsp_tag    = head.tag;

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: a fake combinational ALU, a transaction-level
// model (queue of outstanding ops with visibility times), a per-cycle
// compare process, and directed tests with literal expectations.
module tb_alu_req_driver;
  import alu_req_driver_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic             flush     = 1'b0;
  logic             req_valid = 1'b0;
  logic             rsp_ready = 1'b0;
  dword_t           req_a     = '0;
  dword_t           req_b     = '0;
  aluop_t           req_op    = ALU_ADD;
  logic [TAG_W-1:0] req_tag   = '0;
  logic             req_ready, rsp_valid, rsp_zero;
  dword_t           rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      op_count;

  alu_req_driver_if alu ();

  alu_req_driver #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu(alu.initiator),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .op_count(op_count)
  );

  function automatic dword_t alu_f(dword_t a, dword_t b, aluop_t op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {63'd0, $signed(a) < $signed(b)};
      ALU_SLL: return a << b[5:0];
      default: return a >> b[5:0];
    endcase
  endfunction

  assign alu.aluout = alu_f(alu.porta, alu.portb, alu.ALUOp);
  assign alu.zero   = (alu.aluout == '0);

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    dword_t           res;
    logic             z;
    logic [TAG_W-1:0] tag;
    int               vis;   // edge index after which it is visible
  } exp_t;

  exp_t        q[$];
  int          ecnt  = 0;
  logic [31:0] m_cnt = '0;
  dword_t      m_a   = '0, m_b = '0;
  aluop_t      m_op  = ALU_ADD;

  // Model step: evaluate pre-edge handshake, then apply the edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      ecnt  = 0;
      m_cnt = '0;
      m_a   = '0;
      m_b   = '0;
      m_op  = aluop_t'(0);
    end else begin
      bit v, p, r, acc;
      dword_t res;
      v   = (q.size() > 0) && (q[0].vis <= ecnt);
      p   = v && rsp_ready;
      r   = !flush && ((q.size() - int'(p)) < DEPTH);
      acc = req_valid && r;
      ecnt++;
      if (flush) q.delete();
      else begin
        if (p) void'(q.pop_front());
        foreach (q[i]) if (q[i].vis == ecnt) m_cnt++;
        if (acc) begin
          res = alu_f(req_a, req_b, req_op);
          q.push_back('{res: res, z: (res == '0), tag: req_tag, vis: ecnt + 1});
          m_a  = req_a;
          m_b  = req_b;
          m_op = req_op;
        end
      end
    end
  end

  // ---------------- compare ----------------
  bit               chk_en = 1'b0;
  logic [TAG_W-1:0] got_tags[$];
  int               pop_cyc[$];
  int               stalls = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      bit ev, pn, er;
      ev = !RST && (q.size() > 0) && (q[0].vis <= ecnt);
      pn = ev && rsp_ready;
      er = !RST && !flush && ((q.size() - int'(pn)) < DEPTH);
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("op_count", 64'(op_count), 64'(m_cnt));
      chk("porta", alu.porta, m_a);
      chk("portb", alu.portb, m_b);
      chk("ALUOp", 64'(alu.ALUOp), 64'(m_op));
      if (ev) begin
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_zero", 64'(rsp_zero), 64'(q[0].z));
        chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      end
      if (pn) begin
        got_tags.push_back(rsp_tag);
        pop_cyc.push_back(ecnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(dword_t a, dword_t b, aluop_t op, logic [TAG_W-1:0] tag);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge CLK);
      if (req_ready) done = 1'b1;
      else stalls++;
      tick();
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] base;

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_porta", alu.porta, 64'd0);
    tick();
    RST = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // single ADD with 2-edge latency
    tick();
    send(64'd5, 64'd7, ALU_ADD, 4'd3);
    chk("add_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("add_valid", 64'(rsp_valid), 64'd1);
    chk("add_result", rsp_result, 64'd12);
    chk("add_zero", 64'(rsp_zero), 64'd0);
    chk("add_tag", 64'(rsp_tag), 64'd3);
    chk("add_opcnt", 64'(op_count), 64'd1);
    rsp_ready = 1'b1;

    // SUB producing zero
    send(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, ALU_SUB, 4'd5);
    tick();
    chk("sub_result", rsp_result, 64'd0);
    chk("sub_zero", 64'(rsp_zero), 64'd1);
    tick();

    // backpressure: only two accepted while rsp_ready is low
    rsp_ready = 1'b0;
    got_tags.delete();
    base = op_count;
    send(64'd10, 64'd1, ALU_ADD, 4'd0);
    send(64'd20, 64'd2, ALU_ADD, 4'd1);
    req_valid = 1'b1;
    req_tag   = 4'd2;
    repeat (3) tick();
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_opcnt", 64'(op_count - base), 64'd2);
    rsp_ready = 1'b1;
    send(64'd30, 64'd3, ALU_ADD, 4'd2);
    send(64'd40, 64'd4, ALU_ADD, 4'd3);
    repeat (4) tick();
    chk("bp_count", 64'(got_tags.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_tags.size()) chk("bp_order", 64'(got_tags[i]), 64'(i));

    // streaming 16 back-to-back
    stalls = 0;
    base   = op_count;
    got_tags.delete();
    pop_cyc.delete();
    for (int i = 0; i < 16; i++)
      send(64'(i * 3 + 100), 64'(i + 1), aluop_t'(i % 8), 4'(i));
    repeat (3) tick();
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_rsps", 64'(got_tags.size()), 64'd16);
    if (pop_cyc.size() == 16)
      chk("stream_consec", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);
    chk("stream_opcnt", 64'(op_count - base), 64'd16);

    // flush with one queued and one in flight
    rsp_ready = 1'b0;
    send(64'd1, 64'd2, ALU_ADD, 4'd7);
    send(64'd3, 64'd4, ALU_ADD, 4'd8);
    base  = op_count;
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    chk("flush_opcnt", 64'(op_count), 64'(base));
    rsp_ready = 1'b1;
    send(64'd100, 64'd1, ALU_SUB, 4'd9);
    tick();
    chk("post_flush_valid", 64'(rsp_valid), 64'd1);
    chk("post_flush_result", rsp_result, 64'd99);
    chk("post_flush_tag", 64'(rsp_tag), 64'd9);

    // async reset mid-stream
    req_valid = 1'b1;
    req_a     = 64'd10;
    req_b     = 64'd20;
    req_op    = ALU_ADD;
    req_tag   = 4'd1;
    repeat (3) @(posedge CLK);
    #3;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    RST = 1'b1;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_porta", alu.porta, 64'd0);
    chk("arst_portb", alu.portb, 64'd0);
    chk("arst_opcnt", 64'(op_count), 64'd0);
    req_valid = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    tick();
    chk("rel_ready", 64'(req_ready), 64'd1);
    chk("rel_opcnt", 64'(op_count), 64'd0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
